sram_lat_slave: RTL

- Parametrised next-generation on-chip SRAM slave for the NPC memory bus. Keeps the valid/ready/wen/wmask slave handshake of the existing SRAM model.
- Replaces DPI memory access with an internal synthesizable array, so the block behaves the same in simulation and synthesis.
- Adds a configurable access latency, generic data width and depth, and an error response for bad accesses.
- Used as IFU/LSU backing store and as a latency-injection target for testing the bus masters.

---
 rtl/sram_lat_slave.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sram_lat_slave.sv
// sram_lat_slave
// On-chip SRAM slave for the NPC memory bus. It uses the valid/ready/wen/wmask
// slave handshake and has a synthesizable word array, a configurable
// request-to-response latency and an error response for bad addresses.
// The request is latched when it is accepted. The array access happens on the
// edge that enters RESP. ready is high for exactly one cycle in RESP.

module sram_lat_slave #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr,
    input  logic                valid,
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic                wen,
    output logic                err
);

    localparam int unsigned     BYTES      = DATA_W / 8;
    localparam int unsigned     OFF_SHIFT  = $clog2(BYTES);
    localparam int unsigned     IDX_SHIFT  = OFF_SHIFT + DEPTH_LOG2;
    localparam int unsigned     DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0]     ALIGN_MASK = 32'(BYTES - 1);
    localparam longint unsigned MEM_BYTES  = longint'(BYTES) << DEPTH_LOG2;
    localparam longint unsigned END_ADDR   = longint'(BASE_ADDR) + MEM_BYTES;
    localparam logic [3:0]      CNT_INIT   = 4'(LATENCY - 1);

    // Reject configurations that the address decode cannot represent.
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_chk_data_w
        $error("sram_lat_slave: DATA_W must be a non-zero multiple of 8");
    end
    if (LATENCY < 1 || LATENCY > 15) begin : g_chk_latency
        $error("sram_lat_slave: LATENCY must be in 1..15");
    end
    if (END_ADDR > 64'h1_0000_0000) begin : g_chk_wrap
        $error("sram_lat_slave: BASE_ADDR + array size wraps past 2**32");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [31:0]         addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BYTES-1:0]    wmask_q;
    logic                wen_q;
    logic                ready_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    // The access fields come from the live inputs in IDLE, because LATENCY=1
    // completes on the acceptance edge. In all other states they come from
    // the latched copy.
    logic                use_inputs;
    logic [31:0]         acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [BYTES-1:0]    acc_wmask;
    logic                acc_wen;
    logic [31:0]         acc_offset;
    logic                acc_below;
    logic                acc_beyond;
    logic                acc_misaligned;
    logic                acc_err;
    idx_t                acc_idx;
    logic                enter_resp;
    logic                mem_we;

    assign use_inputs     = (state_q == ST_IDLE);
    assign acc_addr       = use_inputs ? addr  : addr_q;
    assign acc_wdata      = use_inputs ? wdata : wdata_q;
    assign acc_wmask      = use_inputs ? wmask : wmask_q;
    assign acc_wen        = use_inputs ? wen   : wen_q;

    assign acc_offset     = acc_addr - BASE_ADDR;
    assign acc_below      = (acc_addr < BASE_ADDR);
    assign acc_beyond     = ((acc_offset >> IDX_SHIFT) != 32'd0);
    assign acc_misaligned = ((acc_addr & ALIGN_MASK) != 32'd0);
    assign acc_err        = acc_below | acc_beyond | acc_misaligned;
    assign acc_idx        = idx_t'(acc_offset >> OFF_SHIFT);

    // The edge that moves the FSM into RESP is the edge that performs the access.
    assign enter_resp = ((state_q == ST_IDLE) && valid && (LATENCY == 1))
                      || ((state_q == ST_WAIT) && (cnt_q == 4'd1));

    // Holding rst low also blocks a commit on a clock edge.
    // A write that is pending when reset arrives is therefore never committed.
    assign mem_we = enter_resp && !acc_err && acc_wen && rst;

    // Byte-lane write into the array for a good write access.
    // NOTE: the array has no reset. Only the control path and the output
    // registers are reset. This keeps the array mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (acc_wmask[b]) begin
                    mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Control FSM with registered ready/err/rdata.
    // NOTE: every state register here uses non-blocking assignment. All reads
    // in this block then see the values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
            wmask_q <= '0;
            wen_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wmask_q <= wmask;
                        wen_q   <= wen;
                        if (LATENCY == 1) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (enter_resp) begin
                ready_q <= 1'b1;
                err_q   <= acc_err;
                if (!acc_wen) begin
                    rdata_q <= acc_err ? '0 : mem[acc_idx];
                end
            end
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule
